// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions used by both the UART-side writer and the VGA-side reader.
package fb_pkg;

  localparam int RAM_WIDTH      = 32;
  localparam int RAM_DEPTH      = (480 * 360 * 24) / RAM_WIDTH;
  localparam int ADDR_BITS      = $clog2(RAM_DEPTH);
  localparam int BYTES_PER_WORD = RAM_WIDTH / 8;
  localparam int TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    FULL
  } wr_state_e;

endpackage

// File: rtl/ram_writer_byte_packer.sv
// Packs incoming bytes MSB-first into RAM_WIDTH-bit words; word_valid flags the byte that completes a word.
module byte_packer
  import fb_pkg::*;
#(
  parameter int RAM_WIDTH = fb_pkg::RAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [7:0]           byte_in,
  output logic [RAM_WIDTH-1:0] word_next,
  output logic                 word_valid
);

  localparam int BPW = RAM_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [RAM_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RAM_WIDTH+7:0] shifted;

  // word_next is the word as it looks with the incoming byte appended, so a completing byte can go straight to data_out
  always_comb begin
    shifted    = {shift_q, byte_in};
    word_next  = shifted[RAM_WIDTH-1:0];
    word_valid = load && !clear && (count_q == CW'(BPW - 1));
    shift_d    = shift_q;
    count_d    = count_q;
    if (clear) begin
      shift_d = '0;
      count_d = '0;
    end else if (load) begin
      shift_d = word_valid ? '0 : word_next;
      count_d = word_valid ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_writer.sv
// Write side of the serial-to-VGA frame buffer: turns UART bytes into sequential single-cycle RAM word writes.
module ram_writer
  import fb_pkg::*;
#(
  parameter int RAM_WIDTH      = fb_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH      = fb_pkg::RAM_DEPTH,
  parameter int TIMEOUT_CYCLES = fb_pkg::TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  input  logic                         frame_restart,
  output logic                         we,
  output logic [$clog2(RAM_DEPTH)-1:0] addr,
  output logic [RAM_WIDTH-1:0]         data_out,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  wr_state_e            state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [TW-1:0]        timeout_q, timeout_d;
  logic [RAM_WIDTH-1:0] data_q, data_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic                 discard;
  logic                 last_addr;
  logic                 word_valid;
  logic [RAM_WIDTH-1:0] word_next;

  byte_packer #(
    .RAM_WIDTH(RAM_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (frame_restart || discard),
    .load      (accept),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_valid(word_valid)
  );

  // Bytes are refused in FULL and during the frame's final write, and a restart always wins over a byte
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    done_d    = 1'b0;
    discard   = 1'b0;
    last_addr = (addr_q == AW'(RAM_DEPTH - 1));
    accept    = rx_ready && !frame_restart && (state_q != FULL) && !((state_q == WRITE) && last_addr);

    case (state_q)
      IDLE: begin
        if (accept) state_d = word_valid ? WRITE : ASSEMBLE;
      end
      ASSEMBLE: begin
        if (accept) begin
          timeout_d = '0;
          if (word_valid) state_d = WRITE;
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          discard   = 1'b1;
          timeout_d = '0;
          state_d   = IDLE;
        end else begin
          timeout_d = timeout_q + TW'(1);
        end
      end
      WRITE: begin
        if (last_addr) begin
          state_d = FULL;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = accept ? (word_valid ? WRITE : ASSEMBLE) : IDLE;
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: state_d = IDLE;
    endcase

    if (word_valid) data_d = word_next;

    if (frame_restart) begin
      state_d   = IDLE;
      addr_d    = '0;
      timeout_d = '0;
      done_d    = 1'b0;
    end

    we_d   = (state_d == WRITE);
    busy_d = (state_d == ASSEMBLE) || (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      timeout_q <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      we_q      <= we_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign data_out   = data_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer: directed vectors and sequences, then random bytes against a frame-level model.
module tb_ram_writer;

  localparam int W   = 32;
  localparam int D   = 4;
  localparam int T   = 16;
  localparam int AW  = $clog2(D);
  localparam int BPW = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          frame_restart;
  logic          we;
  logic [AW-1:0] addr;
  logic [W-1:0]  data_out;
  logic          frame_done;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;
  int weCount    = 0;
  int doneCount  = 0;

  // Frame-level model: bytes held for the current word, words written so far, idle run length
  logic [7:0]    partQ[$];
  int            idleCnt;
  int            nWritten;
  logic          mWe;
  logic          mDone;
  logic [W-1:0]  mData;

  typedef struct {
    logic          rx;
    logic [7:0]    b;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [W-1:0]  expData;
    logic          expBusy;
  } vec_t;

  vec_t vecs[9];

  ram_writer #(
    .RAM_WIDTH     (W),
    .RAM_DEPTH     (D),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .frame_restart(frame_restart),
    .we           (we),
    .addr         (addr),
    .data_out     (data_out),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) weCount++;
    if (frame_done) doneCount++;
  end

  task automatic modelReset();
    partQ.delete();
    idleCnt  = 0;
    nWritten = 0;
    mWe      = 1'b0;
    mDone    = 1'b0;
    mData    = '0;
  endtask

  task automatic modelStep(input logic rx, input logic [7:0] b, input logic rs);
    logic prevWe;
    prevWe = mWe;
    if (rs) begin
      partQ.delete();
      idleCnt  = 0;
      nWritten = 0;
      mWe      = 1'b0;
      mDone    = 1'b0;
    end else begin
      mDone = prevWe && (nWritten == D);
      mWe   = 1'b0;
      if (rx && nWritten < D) begin
        partQ.push_back(b);
        idleCnt = 0;
        if (partQ.size() == BPW) begin
          mData = '0;
          foreach (partQ[i]) mData = (mData << 8) | W'(partQ[i]);
          partQ.delete();
          nWritten++;
          mWe = 1'b1;
        end
      end else if (partQ.size() > 0) begin
        idleCnt++;
        if (idleCnt == T) begin
          partQ.delete();
          idleCnt = 0;
        end
      end
    end
  endtask

  function automatic logic [AW-1:0] modelAddr();
    if (mWe) return AW'(nWritten - 1);
    return AW'((nWritten < D) ? nWritten : D - 1);
  endfunction

  task automatic applyStimulus(input logic rx, input logic [7:0] b, input logic rs);
    rx_ready      = rx;
    rx_data       = b;
    frame_restart = rs;
    @(posedge clk);
    #1;
    rx_ready      = 1'b0;
    frame_restart = 1'b0;
    modelStep(rx, b, rs);
  endtask

  task automatic checkOutput(input string name, input logic expWe, input logic [AW-1:0] expAddr,
                             input logic [W-1:0] expData, input logic expDone, input logic expBusy);
    compared++;
    if ({we, addr, data_out, frame_done, busy} !== {expWe, expAddr, expData, expDone, expBusy}) begin
      mismatched++;
      $display("[TB] FAIL %s: got we=%0b addr=%0d data=%08h done=%0b busy=%0b, expected we=%0b addr=%0d data=%08h done=%0b busy=%0b",
               name, we, addr, data_out, frame_done, busy, expWe, expAddr, expData, expDone, expBusy);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic doReset();
    rst           = 1'b1;
    rx_ready      = 1'b0;
    frame_restart = 1'b0;
    rx_data       = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [7:0] t1Bytes[4];
    int weStart;
    int doneStart;
    int gap;
    int r;

    t1Bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    vecs[0] = '{1'b1, 8'h01, 1'b0, 2'd0, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 2'd0, 32'h0, 1'b1};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 2'd0, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 8'h04, 1'b1, 2'd0, 32'h01020304, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 2'd1, 32'h01020304, 1'b1};
    vecs[5] = '{1'b1, 8'h06, 1'b0, 2'd1, 32'h01020304, 1'b1};
    vecs[6] = '{1'b1, 8'h07, 1'b0, 2'd1, 32'h01020304, 1'b1};
    vecs[7] = '{1'b1, 8'h08, 1'b1, 2'd1, 32'h05060708, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 2'd2, 32'h05060708, 1'b0};

    // Slow bytes with idle gaps
    doReset();
    checkOutput("reset", 1'b0, '0, '0, 1'b0, 1'b0);
    weStart = weCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t1Bytes[i], 1'b0);
      if (i < 3) begin
        checkOutput("slow hold", 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
      end
    end
    checkOutput("slow write", 1'b1, 2'd0, 32'hAABBCCDD, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("slow after", 1'b0, 2'd1, 32'hAABBCCDD, 1'b0, 1'b0);
    checkCount("slow we pulses", weCount - weStart, 1);

    // Back-to-back bytes, including one landing in the WRITE cycle
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rx, vecs[i].b, 1'b0);
      checkOutput($sformatf("b2b vec %0d", i), vecs[i].expWe, vecs[i].expAddr, vecs[i].expData, 1'b0, vecs[i].expBusy);
    end

    // Fill the whole frame and overrun it
    doReset();
    weStart   = weCount;
    doneStart = doneCount;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0);
    checkOutput("full last write", 1'b1, 2'd3, 32'h0D0E0F10, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("full done pulse", 1'b0, 2'd3, 32'h0D0E0F10, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("full done low", 1'b0, 2'd3, 32'h0D0E0F10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("full ignores bytes", 1'b0, 2'd3, 32'h0D0E0F10, 1'b0, 1'b0);
    checkCount("full we pulses", weCount - weStart, 4);
    checkCount("full done pulses", doneCount - doneStart, 1);

    // Partial word discarded by the idle timeout
    doReset();
    weStart = weCount;
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    repeat (T - 1) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("timeout not yet", 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("timeout discard", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("timeout new word", 1'b1, 2'd0, 32'h11223344, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkCount("timeout we pulses", weCount - weStart, 1);

    // frame_restart beats a simultaneous byte
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("restart before", 1'b0, 2'd3, 32'h090A0B0C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("restart addr0", 1'b0, 2'd0, 32'h090A0B0C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h51, 1'b0);
    applyStimulus(1'b1, 8'h52, 1'b0);
    applyStimulus(1'b1, 8'h53, 1'b0);
    applyStimulus(1'b1, 8'h54, 1'b0);
    checkOutput("restart new word", 1'b1, 2'd0, 32'h51525354, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a word
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA1 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hB1 + 8'(i), 1'b0);
    checkOutput("mid word", 1'b0, 2'd1, 32'hA1A2A3A4, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async reset", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC1 + 8'(i), 1'b0);
    checkOutput("after reset word", 1'b1, 2'd0, 32'hC1C2C3C4, 1'b0, 1'b1);

    // Random traffic against the model
    doReset();
    for (int n = 0; n < 600; n++) begin
      r   = int'($urandom_range(0, 9));
      gap = (r < 7) ? int'($urandom_range(0, 3)) : ((r < 9) ? 0 : int'($urandom_range(20, 24)));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 8'h00, ($urandom_range(0, 199) == 0));
        checkOutput("random idle", mWe, modelAddr(), mData, mDone, mWe || (partQ.size() > 0));
      end
      applyStimulus(1'b1, 8'($urandom), ($urandom_range(0, 99) == 0));
      checkOutput("random byte", mWe, modelAddr(), mData, mDone, mWe || (partQ.size() > 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
